// File: rtl/cpu_accel_bridge_pkg.sv
// cpu_accel_pkg: shared defaults and types for the cpu accelerator bridge.
package cpu_accel_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACCEL_ID_WIDTH_DEF = 4;
  typedef logic [ACCEL_ID_WIDTH_DEF-1:0] accel_id_t;
endpackage

// File: rtl/cpu_accel_bridge_if.sv
// cpu_accel_bridge_if: cpu accelerator port plus per-channel valid/ready streams.
interface cpu_accel_bridge_if
  import cpu_accel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_ACCELS = 4,
  parameter int ACCEL_ID_WIDTH = ACCEL_ID_WIDTH_DEF
);
  logic [ACCEL_ID_WIDTH-1:0] accel_id;
  logic accel_can_read;
  logic accel_can_write;
  logic accel_read_enable;
  logic [DATA_WIDTH-1:0] accel_read_data;
  logic accel_write_enable;
  logic [DATA_WIDTH-1:0] accel_write_data;
  logic [NUM_ACCELS-1:0] cmd_valid;
  logic [NUM_ACCELS*DATA_WIDTH-1:0] cmd_data;
  logic [NUM_ACCELS-1:0] cmd_ready;
  logic [NUM_ACCELS-1:0] res_valid;
  logic [NUM_ACCELS*DATA_WIDTH-1:0] res_data;
  logic [NUM_ACCELS-1:0] res_ready;
  modport master (
    output accel_id, accel_read_enable, accel_write_enable, accel_write_data, cmd_ready, res_valid, res_data,
    input accel_can_read, accel_can_write, accel_read_data, cmd_valid, cmd_data, res_ready
  );
  modport slave (
    input accel_id, accel_read_enable, accel_write_enable, accel_write_data, cmd_ready, res_valid, res_data,
    output accel_can_read, accel_can_write, accel_read_data, cmd_valid, cmd_data, res_ready
  );
endinterface

// File: rtl/cpu_accel_bridge_fifo.sv
// accel_fifo: show-ahead FIFO; flags and head depend only on registered state.
module accel_fifo
  import cpu_accel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic empty,
  output logic full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    do_push = push && !full;
    do_pop = pop && !empty;
    head = empty ? '0 : mem_q[rd_q];
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cpu_accel_bridge.sv
// cpu_accel_bridge: routes cpu accelerator port traffic to per-channel command/result FIFOs.
module cpu_accel_bridge
  import cpu_accel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_ACCELS = 4,
  parameter int ACCEL_ID_WIDTH = ACCEL_ID_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  cpu_accel_bridge_if.slave bus
);
  logic [NUM_ACCELS-1:0] sel, cmd_empty, cmd_full, res_empty, res_full;
  logic [NUM_ACCELS*DATA_WIDTH-1:0] cmd_data;
  logic [DATA_WIDTH-1:0] res_head [NUM_ACCELS];
  genvar i;
  generate
    for (i = 0; i < NUM_ACCELS; i++) begin : g_ch
      // out-of-range ids match no channel, so they gate off both enables
      assign sel[i] = bus.accel_id == ACCEL_ID_WIDTH'(i);
      accel_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_cmd (
        .clk(clk), .rst(rst),
        .push(sel[i] && bus.accel_write_enable), .push_data(bus.accel_write_data),
        .pop(bus.cmd_ready[i]), .head(cmd_data[i*DATA_WIDTH +: DATA_WIDTH]),
        .empty(cmd_empty[i]), .full(cmd_full[i])
      );
      accel_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_res (
        .clk(clk), .rst(rst),
        .push(bus.res_valid[i]), .push_data(bus.res_data[i*DATA_WIDTH +: DATA_WIDTH]),
        .pop(sel[i] && bus.accel_read_enable), .head(res_head[i]),
        .empty(res_empty[i]), .full(res_full[i])
      );
    end
  endgenerate
  always_comb begin
    bus.cmd_valid = ~cmd_empty;
    bus.cmd_data = cmd_data;
    bus.res_ready = ~res_full;
    bus.accel_can_read = |(sel & ~res_empty);
    bus.accel_can_write = |(sel & ~cmd_full);
    bus.accel_read_data = '0;
    for (int k = 0; k < NUM_ACCELS; k++) bus.accel_read_data = bus.accel_read_data | (sel[k] ? res_head[k] : '0);
  end
endmodule

// File: tb/tb_cpu_accel_bridge.sv
// tb_cpu_accel_bridge: directed and random traffic checked against queue-based channel model.
module tb_cpu_accel_bridge;
  import cpu_accel_pkg::*;
  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_accel_bridge_if #(.DATA_WIDTH(W), .NUM_ACCELS(N), .ACCEL_ID_WIDTH(4)) b ();
  cpu_accel_bridge #(.DATA_WIDTH(W), .NUM_ACCELS(N), .ACCEL_ID_WIDTH(4), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  int checks = 0;
  int errs = 0;
  logic [W-1:0] cq [N][$];
  logic [W-1:0] rq [N][$];
  logic [W-1:0] sent [$];
  logic [W-1:0] got [$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model();
    int id;
    bit wp, rp;
    bit cp [N];
    bit pp [N];
    id = int'(b.accel_id);
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        cq[c].delete();
        rq[c].delete();
      end
      return;
    end
    wp = 0;
    rp = 0;
    if (id < N) begin
      wp = b.accel_write_enable && cq[id].size() < D;
      rp = b.accel_read_enable && rq[id].size() > 0;
    end
    for (int c = 0; c < N; c++) begin
      cp[c] = b.cmd_ready[c] && cq[c].size() > 0;
      pp[c] = b.res_valid[c] && rq[c].size() < D;
    end
    for (int c = 0; c < N; c++) begin
      if (cp[c]) void'(cq[c].pop_front());
      if (pp[c]) rq[c].push_back(b.res_data[c*W +: W]);
    end
    if (wp) cq[id].push_back(b.accel_write_data);
    if (rp) void'(rq[id].pop_front());
  endtask
  task automatic check_all();
    int id;
    bit ecr, ecw;
    logic [W-1:0] er;
    id = int'(b.accel_id);
    ecr = 0;
    ecw = 0;
    er = '0;
    if (id < N) begin
      ecr = rq[id].size() > 0;
      ecw = cq[id].size() < D;
      if (ecr) er = rq[id][0];
    end
    chk("can_read", b.accel_can_read, ecr);
    chk("can_write", b.accel_can_write, ecw);
    chk("read_data", b.accel_read_data, er);
    for (int c = 0; c < N; c++) begin
      chk("cmd_valid", b.cmd_valid[c], cq[c].size() > 0);
      chk("res_ready", b.res_ready[c], rq[c].size() < D);
      if (cq[c].size() > 0) chk("cmd_data", b.cmd_data[c*W +: W], cq[c][0]);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [W-1:0] w;
    b.accel_id = '0;
    b.accel_read_enable = 0;
    b.accel_write_enable = 0;
    b.accel_write_data = '0;
    b.cmd_ready = '0;
    b.res_valid = '0;
    b.res_data = '0;
    cycle();
    cycle();
    rst = 0;
    cycle();
    chk("rst_can_read", b.accel_can_read, 0);
    chk("rst_can_write", b.accel_can_write, 1);
    chk("rst_cmd_valid", b.cmd_valid, 4'h0);
    chk("rst_res_ready", b.res_ready, 4'hF);
    chk("rst_read_data", b.accel_read_data, 0);
    b.accel_id = 2;
    b.accel_write_enable = 1;
    for (int k = 1; k <= 5; k++) begin
      b.accel_write_data = W'(k * 16'h1111);
      cycle();
      if (k == 1) chk("cmd_valid2_first", b.cmd_valid, 4'h4);
      if (k == 4) chk("can_write_full", b.accel_can_write, 0);
    end
    b.accel_write_enable = 0;
    chk("cmd_head_after_drop", b.cmd_data[2*W +: W], 16'h1111);
    b.cmd_ready[2] = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("cmd_order", b.cmd_data[2*W +: W], W'(k * 16'h1111));
      chk("other_idle", b.cmd_valid & 4'hB, 4'h0);
      cycle();
    end
    b.cmd_ready = '0;
    chk("cmd2_drained", b.cmd_valid, 4'h0);
    b.res_valid[1] = 1;
    b.res_data[1*W +: W] = 16'd42;
    cycle();
    b.res_valid = '0;
    b.accel_id = 1;
    #1;
    chk("res1_can_read", b.accel_can_read, 1);
    chk("res1_data", b.accel_read_data, 16'd42);
    b.accel_read_enable = 1;
    cycle();
    b.accel_read_enable = 0;
    #1;
    chk("res1_popped_cr", b.accel_can_read, 0);
    chk("res1_popped_rd", b.accel_read_data, 0);
    b.accel_id = 3;
    b.res_valid[3] = 1;
    for (int k = 1; k <= 4; k++) begin
      b.res_data[3*W +: W] = W'(16'h0A00 + k);
      cycle();
    end
    b.res_data[3*W +: W] = 16'h0A05;
    b.accel_read_enable = 1;
    #1;
    chk("res3_full_ready", b.res_ready[3], 0);
    chk("res3_head1", b.accel_read_data, 16'h0A01);
    cycle();
    b.res_valid = '0;
    b.accel_read_enable = 0;
    #1;
    chk("res3_head2", b.accel_read_data, 16'h0A02);
    chk("res3_ready_again", b.res_ready[3], 1);
    b.accel_read_enable = 1;
    for (int k = 0; k < 3; k++) cycle();
    b.accel_read_enable = 0;
    chk("res3_count3_empty", b.accel_can_read, 0);
    b.accel_id = 0;
    b.cmd_ready[0] = 1;
    for (int k = 0; k < 10; k++) begin
      b.accel_write_enable = k < 8;
      w = W'($urandom);
      b.accel_write_data = w;
      if (k < 8) sent.push_back(w);
      #1;
      if (b.cmd_valid[0]) got.push_back(b.cmd_data[W-1:0]);
      cycle();
    end
    b.cmd_ready = '0;
    b.accel_write_enable = 0;
    chk("wrap_count", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk("wrap_order", got[k], sent[k]);
    b.accel_id = 1;
    b.accel_write_enable = 1;
    b.accel_write_data = 16'hBEEF;
    cycle();
    cycle();
    b.res_valid[1] = 1;
    b.res_data[1*W +: W] = 16'h7777;
    cycle();
    b.res_valid = '0;
    b.accel_id = 7;
    b.accel_read_enable = 1;
    #1;
    chk("bad_id_can_read", b.accel_can_read, 0);
    chk("bad_id_can_write", b.accel_can_write, 0);
    chk("bad_id_read_data", b.accel_read_data, 0);
    cycle();
    cycle();
    b.accel_write_enable = 0;
    b.accel_read_enable = 0;
    b.accel_id = 1;
    cycle();
    chk("bad_id_no_change", b.cmd_valid, 4'h2);
    chk("bad_id_res_kept", b.accel_read_data, 16'h7777);
    rst = 1;
    cycle();
    rst = 0;
    chk("midq_rst_cmd_valid", b.cmd_valid, 4'h0);
    chk("midq_rst_res_ready", b.res_ready, 4'hF);
    chk("midq_rst_can_read", b.accel_can_read, 0);
    for (int k = 0; k < 400; k++) begin
      accel_id_t id;
      id = accel_id_t'($urandom_range(0, 7));
      b.accel_id = id;
      b.accel_write_enable = $urandom_range(0, 1) == 1;
      b.accel_read_enable = $urandom_range(0, 1) == 1;
      b.accel_write_data = W'($urandom);
      b.cmd_ready = 4'($urandom);
      b.res_valid = 4'($urandom);
      b.res_data = {$urandom, $urandom};
      rst = $urandom_range(0, 99) == 0;
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
